// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter
//   Shares one I2C master engine among NUM_REQ requesters. Each request is
//   served in turn, starting from the requester after the one served last.
//   The selected transaction payload is latched onto the m_* outputs. The
//   block then pulses m_start and waits for m_done or a timeout. It returns
//   read data and done/err to the granted requester, then holds the bus idle
//   for GAP_CYCLES before it arbitrates again.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req                 per-requester request level
//   req_rw              per-requester direction (1 = read, 0 = write)
//   req_slave_addr      packed 7-bit slave addresses, requester i at [7i+6:7i]
//   req_pointer         packed 7-bit register pointers, same packing
//   req_wdata           packed write bytes, requester i at [8i+7:8i]
//   grant               one-hot grant, held for the whole transaction
//   done                one-cycle completion pulse to the granted requester
//   rdata               read byte (00 for writes, FF on timeout), held to next done
//   err                 one-cycle timeout flag, coincident with done
//   busy                high from grant until the end of the idle gap
//   m_start             one-cycle start pulse to the I2C master
//   m_rw, m_slave_addr,
//   m_pointer, m_wdata  transaction payload to the master, latched at grant
//   m_done              master completion pulse
//   m_data_read         master read byte, valid with m_done
//
// GAP_CYCLES must be at least 1.

module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_slave_addr,
    input  logic [7*NUM_REQ-1:0] req_pointer,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 busy,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [6:0]           m_slave_addr,
    output logic [6:0]           m_pointer,
    output logic [7:0]           m_wdata,
    input  logic                 m_done,
    input  logic [7:0]           m_data_read
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GCNT_W = $clog2(GAP_CYCLES + 1);

    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = NUM_REQ'(1);
    localparam logic [IDX_W:0]     NUM_REQ_W   = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WAIT_DONE,
        RESP,
        GAP
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  idx;
    logic [TCNT_W-1:0] t_cnt;
    logic [GCNT_W-1:0] g_cnt;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W:0]    cand;

    // Round-robin pick: scan requesters rr_ptr, rr_ptr+1, ... wrapping at
    // NUM_REQ, and take the first one that is requesting.
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            idx          <= '0;
            t_cnt        <= '0;
            g_cnt        <= '0;
            grant        <= '0;
            done         <= '0;
            rdata        <= 8'h00;
            err          <= 1'b0;
            busy         <= 1'b0;
            m_start      <= 1'b0;
            m_rw         <= 1'b0;
            m_slave_addr <= '0;
            m_pointer    <= '0;
            m_wdata      <= '0;
        end else begin
            // Pulse outputs are high for one cycle only, unless a state sets them.
            m_start <= 1'b0;
            done    <= '0;
            err     <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant        <= ONE_HOT_LSB << pick_idx;
                        idx          <= pick_idx;
                        m_rw         <= req_rw[pick_idx];
                        m_slave_addr <= req_slave_addr[7*pick_idx +: 7];
                        m_pointer    <= req_pointer[7*pick_idx +: 7];
                        m_wdata      <= req_wdata[8*pick_idx +: 8];
                        busy         <= 1'b1;
                        state        <= GRANT;
                    end
                end

                GRANT: begin
                    m_start <= 1'b1;
                    t_cnt   <= '0;
                    state   <= WAIT_DONE;
                end

                // t_cnt is 0 in the m_start cycle. The abort fires once it
                // has counted TIMEOUT_CYCLES cycles, so done/err arrive
                // TIMEOUT_CYCLES+1 cycles after m_start. A late m_done in
                // that final cycle still wins.
                WAIT_DONE: begin
                    if (m_done) begin
                        rdata <= m_rw ? m_data_read : 8'h00;
                        done  <= ONE_HOT_LSB << idx;
                        state <= RESP;
                    end else if (t_cnt == TCNT_W'(TIMEOUT_CYCLES)) begin
                        rdata <= 8'hFF;
                        err   <= 1'b1;
                        done  <= ONE_HOT_LSB << idx;
                        state <= RESP;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end

                // done/err were raised on entry and clear here by default.
                RESP: begin
                    rr_ptr <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                    grant  <= '0;
                    g_cnt  <= '0;
                    state  <= GAP;
                end

                GAP: begin
                    if (g_cnt == GCNT_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        g_cnt <= g_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter.
//   dut   : TIMEOUT_CYCLES = 4096. It is driven by a transaction-level master
//           model (run_txn) with directed, round-robin, stability, random and
//           mid-transaction reset scenarios.
//   dut_t : TIMEOUT_CYCLES = 16. It shares the requester inputs, and its
//           m_done is tied low so every transaction it starts times out.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_i2c_master_arbiter;

    localparam int N  = 4;
    localparam int G  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   req_rw = '0;
    logic [7*N-1:0] req_slave_addr = '0;
    logic [7*N-1:0] req_pointer = '0;
    logic [8*N-1:0] req_wdata = '0;
    logic           m_done = 1'b0;
    logic [7:0]     m_data_read = 8'h00;

    logic [N-1:0] grant, done;
    logic [7:0]   rdata, m_wdata;
    logic         err, busy, m_start, m_rw;
    logic [6:0]   m_slave_addr, m_pointer;

    logic [N-1:0] t_grant, t_done;
    logic [7:0]   t_rdata, t_m_wdata;
    logic         t_err, t_busy, t_m_start, t_m_rw;
    logic [6:0]   t_m_slave_addr, t_m_pointer;

    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4096), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
        .req_slave_addr(req_slave_addr), .req_pointer(req_pointer), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata), .err(err), .busy(busy),
        .m_start(m_start), .m_rw(m_rw), .m_slave_addr(m_slave_addr),
        .m_pointer(m_pointer), .m_wdata(m_wdata),
        .m_done(m_done), .m_data_read(m_data_read)
    );

    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(G)) dut_t (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
        .req_slave_addr(req_slave_addr), .req_pointer(req_pointer), .req_wdata(req_wdata),
        .grant(t_grant), .done(t_done), .rdata(t_rdata), .err(t_err), .busy(t_busy),
        .m_start(t_m_start), .m_rw(t_m_rw), .m_slave_addr(t_m_slave_addr),
        .m_pointer(t_m_pointer), .m_wdata(t_m_wdata),
        .m_done(1'b0), .m_data_read(8'h00)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    int last_start = -1000;
    int start_gap  = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after ptr, modulo N.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic set_slot(input int i, input logic rw, input logic [6:0] a,
                            input logic [6:0] p, input logic [7:0] w);
        req_rw[i]              = rw;
        req_slave_addr[7*i +: 7] = a;
        req_pointer[7*i +: 7]    = p;
        req_wdata[8*i +: 8]      = w;
    endtask

    task automatic fill_random_slots();
        for (int i = 0; i < N; i++) begin
            set_slot(i, 1'($urandom), 7'($urandom), 7'($urandom), 8'($urandom));
        end
    endtask

    // Leaves the caller mid-cycle in the first cycle after reset release.
    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        rst_n  = 1'b0;
        req    = r;
        m_done = 1'b0;
        repeat (2) @(negedge clk);
        model_rr = 0;
        rst_n    = 1'b1;
    endtask

    // Called mid-cycle T, with req/payload already driven. The task models
    // the master: it answers lat cycles after m_start and returns mid-cycle
    // in the cycle where the arbiter is idle again.
    task automatic run_txn(input int w, input logic erw, input logic [6:0] ea,
                           input logic [6:0] ep, input logic [7:0] ew, input int lat,
                           input logic [7:0] mrd, input bit scramble, input string tag);
        logic [7:0] exp_rd;
        bit         bad;
        exp_rd = erw ? mrd : 8'h00;

        @(negedge clk); // T+1
        check({tag, " grant"}, 32'(grant), 32'(1 << w));
        check({tag, " m_rw"}, 32'(m_rw), 32'(erw));
        check({tag, " m_slave_addr"}, 32'(m_slave_addr), 32'(ea));
        check({tag, " m_pointer"}, 32'(m_pointer), 32'(ep));
        check({tag, " m_wdata"}, 32'(m_wdata), 32'(ew));
        check({tag, " m_start early"}, 32'(m_start), 32'(0));
        check({tag, " busy"}, 32'(busy), 32'(1));
        if (scramble) begin
            req            = 4'($urandom) & ~(4'(1) << w);
            req_wdata      = ~req_wdata;
            req_slave_addr = ~req_slave_addr;
        end

        @(negedge clk); // T+2
        check({tag, " m_start"}, 32'(m_start), 32'(1));
        check({tag, " m_wdata held"}, 32'(m_wdata), 32'(ew));
        check({tag, " m_slave_addr held"}, 32'(m_slave_addr), 32'(ea));
        start_gap  = cyc - last_start;
        last_start = cyc;

        bad = 1'b0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (done !== '0 || err !== 1'b0 || m_start !== 1'b0) bad = 1'b1;
        end
        m_done      = 1'b1;
        m_data_read = mrd;

        @(negedge clk); // D+1
        m_done      = 1'b0;
        m_data_read = 8'($urandom);
        check({tag, " quiet while waiting"}, 32'(bad), 32'(0));
        check({tag, " done"}, 32'(done), 32'(1 << w));
        check({tag, " err"}, 32'(err), 32'(0));
        check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
        check({tag, " grant in resp"}, 32'(grant), 32'(1 << w));
        model_rr = (w + 1) % N;

        // Gap: a stray m_done here must be ignored.
        bad = 1'b0;
        for (int k = 1; k <= G; k++) begin
            @(negedge clk);
            m_done      = (k == 1);
            m_data_read = 8'h77;
            if (done !== '0 || err !== 1'b0 || grant !== '0 || busy !== 1'b1 || m_start !== 1'b0)
                bad = 1'b1;
        end
        m_done = 1'b0;

        @(negedge clk); // D+2+G
        check({tag, " gap"}, 32'(bad), 32'(0));
        check({tag, " busy dropped"}, 32'(busy), 32'(0));
        check({tag, " rdata held"}, 32'(rdata), 32'(exp_rd));
    endtask

    typedef struct {
        logic [N-1:0] r;
        int           w;
        logic         rw;
        logic [6:0]   a;
        logic [6:0]   p;
        logic [7:0]   wd;
        int           lat;
        logic [7:0]   mrd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vec_t       v;
        bit         bad;
        bit         found;
        int         w;
        logic [N-1:0] r;

        // Hand-derived sequence from reset (rr pointer starts at 0).
        vecs[0] = '{4'b0010, 1, 1'b0, 7'h50, 7'h10, 8'hA5, 200, 8'hEE}; // rr -> 2
        vecs[1] = '{4'b0100, 2, 1'b1, 7'h21, 7'h05, 8'h00, 7,   8'h3C}; // rr -> 3
        vecs[2] = '{4'b1001, 3, 1'b1, 7'h3A, 7'h7F, 8'h11, 0,   8'hC3}; // rr -> 0
        vecs[3] = '{4'b1011, 0, 1'b0, 7'h01, 7'h02, 8'hFF, 3,   8'h55}; // rr -> 1
        vecs[4] = '{4'b1010, 1, 1'b1, 7'h7F, 7'h00, 8'h80, 1,   8'h5A}; // rr -> 2

        // Reset values.
        do_reset('0);
        check("reset grant", 32'(grant), 32'(0));
        check("reset rdata", 32'(rdata), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset m_start", 32'(m_start), 32'(0));
        check("reset m_slave_addr", 32'(m_slave_addr), 32'(0));

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            fill_random_slots();
            set_slot(v.w, v.rw, v.a, v.p, v.wd);
            req = v.r;
            run_txn(v.w, v.rw, v.a, v.p, v.wd, v.lat, v.mrd, 1'b0, $sformatf("vec%0d", i));
        end
        req = '0;

        // Round-robin with every requester held high from reset.
        for (int i = 0; i < N; i++) set_slot(i, 1'(i), 7'(8'h10 + i), 7'(8'h20 + i), 8'(8'h30 + i));
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) begin
            w = i % N;
            run_txn(w, 1'(w), 7'(8'h10 + w), 7'(8'h20 + w), 8'(8'h30 + w), 2 + i, 8'(8'h90 + i),
                    1'b0, $sformatf("rr%0d", i));
            if (i > 0) check($sformatf("rr%0d start spacing ok", i), 32'(start_gap >= G + 1), 32'(1));
        end

        // Payload stability: requester 0 drops req and changes data after grant.
        req = 4'b0001;
        set_slot(0, 1'b0, 7'h2B, 7'h44, 8'h5E);
        run_txn(0, 1'b0, 7'h2B, 7'h44, 8'h5E, 5, 8'h00, 1'b1, "stable");

        // Random transactions checked against the reference arbitration.
        for (int it = 0; it < 30; it++) begin
            fill_random_slots();
            r = 4'($urandom);
            if (r == '0) r = 4'(1) << (it % N);
            req = r;
            w = rr_pick(r, model_rr);
            run_txn(w, req_rw[w], req_slave_addr[7*w +: 7], req_pointer[7*w +: 7],
                    req_wdata[8*w +: 8], $urandom_range(0, 15), 8'($urandom),
                    1'($urandom), $sformatf("rand%0d", it));
        end

        // Timeout on dut_t (TIMEOUT_CYCLES = 16, m_done never asserted).
        fill_random_slots();
        set_slot(1, 1'b0, 7'h66, 7'h33, 8'h99);
        do_reset(4'b0001);
        @(negedge clk); // T+1
        check("to grant", 32'(t_grant), 32'(4'b0001));
        @(negedge clk); // T+2
        check("to m_start", 32'(t_m_start), 32'(1));
        bad = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (t_done !== '0 || t_err !== 1'b0) bad = 1'b1;
        end
        @(negedge clk); // m_start cycle + 17
        check("to no early done", 32'(bad), 32'(0));
        check("to done", 32'(t_done), 32'(4'b0001));
        check("to err", 32'(t_err), 32'(1));
        check("to rdata", 32'(t_rdata), 32'(8'hFF));
        req = 4'b0010;
        @(negedge clk);
        check("to done single", 32'(t_done), 32'(0));
        check("to err single", 32'(t_err), 32'(0));
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (t_busy === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to idle reached", 32'(found), 32'(1));
        @(negedge clk);
        check("to next grant", 32'(t_grant), 32'(4'b0010));
        check("to next addr", 32'(t_m_slave_addr), 32'(7'h66));

        // Reset mid-transaction: leave rr at 3, start requester 3, then reset.
        fill_random_slots();
        do_reset('0);
        set_slot(2, 1'b1, 7'h12, 7'h34, 8'h56);
        req = 4'b0100;
        run_txn(2, 1'b1, 7'h12, 7'h34, 8'h56, 2, 8'hA7, 1'b0, "pre_rst");
        set_slot(3, 1'b1, 7'h7E, 7'h7D, 8'hEF);
        req = 4'b1000;
        repeat (3) @(negedge clk); // WAIT_DONE
        check("mid grant before reset", 32'(grant), 32'(4'b1000));
        rst_n = 1'b0;
        #1;
        check("mid rst grant", 32'(grant), 32'(0));
        check("mid rst done", 32'(done), 32'(0));
        check("mid rst rdata", 32'(rdata), 32'(0));
        check("mid rst err", 32'(err), 32'(0));
        check("mid rst busy", 32'(busy), 32'(0));
        check("mid rst m_start", 32'(m_start), 32'(0));
        check("mid rst m_rw", 32'(m_rw), 32'(0));
        check("mid rst m_slave_addr", 32'(m_slave_addr), 32'(0));
        check("mid rst m_pointer", 32'(m_pointer), 32'(0));
        check("mid rst m_wdata", 32'(m_wdata), 32'(0));
        bad = 1'b0;
        m_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done !== '0) bad = 1'b1;
        end
        m_done = 1'b0;
        set_slot(2, 1'b0, 7'h45, 7'h67, 8'h89);
        req = 4'b1100;
        model_rr = 0;
        rst_n = 1'b1;
        check("mid rst no done", 32'(bad), 32'(0));
        w = rr_pick(4'b1100, model_rr);
        run_txn(w, 1'b0, 7'h45, 7'h67, 8'h89, 4, 8'h00, 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
